// File: rtl/mdu.sv
// Multiply/divide unit: 32-iteration shift-add multiplier and restoring
// divider sharing one 64-bit accumulator, with architectural HI/LO registers.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_nxt;    // mult: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0] dvs;             // multiplicand or divisor magnitude
  logic [31:0] a_raw;           // raw dividend, returned as HI on divide by zero
  logic        is_div, neg_q, neg_r, dz;

  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, diff;
  logic [64:0] sh;
  logic [31:0] res_hi, res_lo;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DONE lasts one cycle and can accept a new start like IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? RUN : IDLE;
      RUN:        if (cnt == 5'd31) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand magnitudes: signed ops run the unsigned core and fix signs at the end
  always_comb begin
    sgn   = ~op[0];
    a_mag = (sgn && a[31]) ? -a : a;
    b_mag = (sgn && b[31]) ? -b : b;
  end

  // One iteration of shift-add (mult) or restoring shift-subtract (div)
  always_comb begin
    sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, dvs} : 33'd0);
    sh   = {acc, 1'b0};
    diff = sh[64:32] - {1'b0, dvs};
    if (is_div) acc_nxt = diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1};
    else        acc_nxt = {sum, acc[31:1]};
  end

  // Final sign fix-up and divide-by-zero override, applied on the last iteration
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (!is_div) begin
      {res_hi, res_lo} = neg_q ? -acc_nxt : acc_nxt;
    end else if (dz) begin
      res_hi = a_raw;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_lo = neg_q ? -acc_nxt[31:0]  : acc_nxt[31:0];
      res_hi = neg_r ? -acc_nxt[63:32] : acc_nxt[63:32];
    end
  end

  // Datapath: operand latch on accept, iterate in RUN, HI/LO moves only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 5'd0;
      acc    <= 64'd0;
      dvs    <= 32'd0;
      a_raw  <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (mthi) hi <= wd;
      if (mtlo) lo <= wd;
      if (start) begin
        acc    <= {32'd0, op[1] ? a_mag : b_mag};
        dvs    <= op[1] ? b_mag : a_mag;
        cnt    <= 5'd0;
        is_div <= op[1];
        neg_q  <= sgn & (a[31] ^ b[31]);
        neg_r  <= sgn & a[31];
        dz     <= (b == 32'd0);
        a_raw  <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a transaction-level model.
module tb_mdu;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0, wd = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0, errors = 0;
  bit running = 1'b1;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] mdu_ref(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Transaction model: an accepted op is pending for 32 cycles, then lands in HI/LO
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = 64'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_done <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) {m_hi, m_lo} <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (mthi) m_hi <= wd;
      if (mtlo) m_lo <= wd;
      if (start) begin
        m_pend <= mdu_ref(op, a, b);
        m_left <= 32;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    #2;
    if (running) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi",   64'(hi),   64'(m_hi));
      chk("lo",   64'(lo),   64'(m_lo));
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(15));
      5: return -32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; optionally inject start+mthi at RUN cycle 'poke'
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string nm, input int poke);
    int nb, k;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
    nb = 0; k = 0;
    while (!done && k < 40) begin
      if (busy) nb++;
      if (k == poke) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom; mthi = 1'b1; wd = 32'h0000_AAAA;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; mthi = 1'b0;
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_busycyc"}, 64'(nb), 64'd32);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int k;
    // Model pinned by hand-computed results
    chk("ref_multu", mdu_ref(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("ref_mult",  mdu_ref(2'd0, -32'd3, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("ref_div",   mdu_ref(2'd2, -32'd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_divz",  mdu_ref(2'd3, 32'h1234_5678, 32'd0), 64'h1234_5678_FFFF_FFFF);
    chk("ref_ovf",   mdu_ref(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);

    // Both moves in one cycle
    mthi = 1'b1; mtlo = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mv_hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mv_lo", 64'(lo), 64'hDEAD_BEEF);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", -1);
    run_op(2'd0, -32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", -1);
    run_op(2'd2, -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", -1);
    run_op(2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "divu_z", -1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf", -1);
    run_op(2'd1, 32'd1000, 32'd3000, 32'd0, 32'd3_000_000, "ignore_busy", 10);

    // Back-to-back start in the DONE cycle
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_first", -1);
    start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end while (!done && k < 40);
    chk("b2b_gap", 64'(k), 64'd33);
    chk("b2b_lo", 64'(lo), 64'd42);

    // Abort mid-RUN
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, "after_abort", -1);

    // Random traffic, including starts/moves while busy and rare resets
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(3) == 0);
      mthi  = ($urandom_range(7) == 0);
      mtlo  = ($urandom_range(7) == 0);
      op    = 2'($urandom_range(3));
      a     = pick();
      b     = pick();
      wd    = $urandom;
      reset = ($urandom_range(699) != 0);
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);
    running = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
